// File: rtl/contador_barrido.sv
// contador_barrido: raster scan timing generator for the 640x480 display path.
// It runs at twice the pixel rate, so every pixel spans two horizontal ticks.
// outcont feeds divisorpor2, which halves it to get the pixel column.
// Optional build macro CONTADOR_CUADROS_EN adds an 8-bit completed-frame counter
// on the output port cuenta_cuadros.
module contador_barrido #(
   parameter int unsigned H_VISIBLE = 1280,
   parameter int unsigned H_FP      = 32,
   parameter int unsigned H_SYNC    = 192,
   parameter int unsigned H_BP      = 96,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        habilitar,
   output logic [10:0] outcont,
   output logic [9:0]  outcontv,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic        fin_linea,
   output logic        fin_cuadro
`ifdef CONTADOR_CUADROS_EN
   ,
   output logic [7:0]  cuenta_cuadros
`endif
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   // Last count of each region, held in 12 bits and compared against zero-extended counts.
   localparam logic [11:0] H_LAST_VIS  = 12'(H_VISIBLE - 1);
   localparam logic [11:0] H_LAST_FP   = 12'(H_VISIBLE + H_FP - 1);
   localparam logic [11:0] H_LAST_SYNC = 12'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST_VIS  = 12'(V_VISIBLE - 1);
   localparam logic [11:0] V_LAST_FP   = 12'(V_VISIBLE + V_FP - 1);
   localparam logic [11:0] V_LAST_SYNC = 12'(V_VISIBLE + V_FP + V_SYNC - 1);
   localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);

   typedef enum logic [1:0] {HVis, HFp, HSync, HBp} h_state_e;
   typedef enum logic [1:0] {VVis, VFp, VSync, VBp} v_state_e;

   logic [10:0] h_cnt_q;
   logic [9:0]  v_cnt_q;
   h_state_e    h_state_q;
   v_state_e    v_state_q;

   logic [11:0] h_ext;
   logic [11:0] v_ext;
   logic        h_at_last;
   logic        v_at_last;
   logic        h_wrap;

   // Zero-extended counts and wrap conditions shared by counters, FSMs and strobes.
   always_comb begin
      h_ext     = {1'b0, h_cnt_q};
      v_ext     = {2'b00, v_cnt_q};
      h_at_last = (h_ext == H_LAST);
      v_at_last = (v_ext == V_LAST);
      h_wrap    = h_at_last & habilitar;
   end

   // Horizontal tick counter; wraps at the end of the line.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         h_cnt_q <= '0;
      end else if (habilitar) begin
         if (h_at_last) begin
            h_cnt_q <= '0;
         end else begin
            h_cnt_q <= h_cnt_q + 11'd1;
         end
      end
   end

   // Vertical line counter; advances only when a line completes.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         v_cnt_q <= '0;
      end else if (h_wrap) begin
         if (v_at_last) begin
            v_cnt_q <= '0;
         end else begin
            v_cnt_q <= v_cnt_q + 10'd1;
         end
      end
   end

   // Horizontal region FSM; moves on the same edge the counter leaves a region.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         h_state_q <= HVis;
      end else if (habilitar) begin
         unique case (h_state_q)
            HVis: begin
               if (h_ext == H_LAST_VIS) begin
                  h_state_q <= HFp;
               end
            end
            HFp: begin
               if (h_ext == H_LAST_FP) begin
                  h_state_q <= HSync;
               end
            end
            HSync: begin
               if (h_ext == H_LAST_SYNC) begin
                  h_state_q <= HBp;
               end
            end
            HBp: begin
               if (h_at_last) begin
                  h_state_q <= HVis;
               end
            end
            default: h_state_q <= HVis;
         endcase
      end
   end

   // Vertical region FSM; same scheme, stepping only on a line wrap.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         v_state_q <= VVis;
      end else if (h_wrap) begin
         unique case (v_state_q)
            VVis: begin
               if (v_ext == V_LAST_VIS) begin
                  v_state_q <= VFp;
               end
            end
            VFp: begin
               if (v_ext == V_LAST_FP) begin
                  v_state_q <= VSync;
               end
            end
            VSync: begin
               if (v_ext == V_LAST_SYNC) begin
                  v_state_q <= VBp;
               end
            end
            VBp: begin
               if (v_at_last) begin
                  v_state_q <= VVis;
               end
            end
            default: v_state_q <= VVis;
         endcase
      end
   end

   // Outputs decode registered state only, so sync and counts never skew.
   always_comb begin
      outcont    = h_cnt_q;
      outcontv   = v_cnt_q;
      hsync      = (h_state_q != HSync);
      vsync      = (v_state_q != VSync);
      video_on   = (h_state_q == HVis) && (v_state_q == VVis);
      fin_linea  = h_wrap;
      fin_cuadro = h_wrap & v_at_last;
   end

`ifdef CONTADOR_CUADROS_EN
   logic [7:0] cuadros_q;

   // Completed-frame counter; wraps naturally at 8 bits.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cuadros_q <= '0;
      end else if (h_wrap && v_at_last) begin
         cuadros_q <= cuadros_q + 8'd1;
      end
   end

   assign cuenta_cuadros = cuadros_q;
`endif

endmodule

// File: tb/tb_contador_barrido.sv
// Bench for contador_barrido: a full-size instance for the horizontal boundaries and a
// reduced-size instance (40 cycles per frame) for vertical sync and frame wrap.
module tb_contador_barrido;

   logic        clk;
   logic        reset_n;
   logic        habilitar;

   logic [10:0] outcont,  s_outcont;
   logic [9:0]  outcontv, s_outcontv;
   logic        hsync, vsync, video_on, fin_linea, fin_cuadro;
   logic        s_hsync, s_vsync, s_video_on, s_fin_linea, s_fin_cuadro;
`ifdef CONTADOR_CUADROS_EN
   logic [7:0]  cuenta_cuadros, s_cuenta_cuadros;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model state: full-size (m*) and reduced (s*) instances.
   int         mh, mv, sh, sv;
   logic [7:0] mcnt, scnt;

   logic [31:0] exp_q[$];
   logic [31:0] exp_s_q[$];

   contador_barrido dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .habilitar  (habilitar),
      .outcont    (outcont),
      .outcontv   (outcontv),
      .hsync      (hsync),
      .vsync      (vsync),
      .video_on   (video_on),
      .fin_linea  (fin_linea),
      .fin_cuadro (fin_cuadro)
`ifdef CONTADOR_CUADROS_EN
      ,
      .cuenta_cuadros (cuenta_cuadros)
`endif
   );

   contador_barrido #(
      .H_VISIBLE (4),
      .H_FP      (1),
      .H_SYNC    (2),
      .H_BP      (1),
      .V_VISIBLE (2),
      .V_FP      (1),
      .V_SYNC    (1),
      .V_BP      (1)
   ) dut_s (
      .clk        (clk),
      .reset_n    (reset_n),
      .habilitar  (habilitar),
      .outcont    (s_outcont),
      .outcontv   (s_outcontv),
      .hsync      (s_hsync),
      .vsync      (s_vsync),
      .video_on   (s_video_on),
      .fin_linea  (s_fin_linea),
      .fin_cuadro (s_fin_cuadro)
`ifdef CONTADOR_CUADROS_EN
      ,
      .cuenta_cuadros (s_cuenta_cuadros)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %h expected %h (model h=%0d v=%0d)",
                  tag, cyc, got, exp, mh, mv);
      end
   endtask

   function automatic logic [31:0] model_out(input int h, input int v, input logic en,
                                             input int hv, input int hf, input int hs,
                                             input int hb, input int vv, input int vf,
                                             input int vs, input int vb);
      int   ht, vt;
      logic hsy, vsy, von, fl, fc;
      ht  = hv + hf + hs + hb;
      vt  = vv + vf + vs + vb;
      hsy = !(h >= hv + hf && h < hv + hf + hs);
      vsy = !(v >= vv + vf && v < vv + vf + vs);
      von = (h < hv) && (v < vv);
      fl  = en && (h == ht - 1);
      fc  = fl && (v == vt - 1);
      return {6'b0, 11'(h), 10'(v), hsy, vsy, von, fl, fc};
   endfunction

   task automatic advance(inout int h, inout int v, inout logic [7:0] c, input logic rst,
                          input logic en, input int ht, input int vt);
      if (!rst) begin
         h = 0;
         v = 0;
         c = 8'd0;
      end else if (en) begin
         if (h == ht - 1) begin
            h = 0;
            if (v == vt - 1) begin
               v = 0;
               c = c + 8'd1;
            end else begin
               v = v + 1;
            end
         end else begin
            h = h + 1;
         end
      end
   endtask

   // One clock: drive inputs on the falling edge, queue expectations, compare, step models.
   task automatic step(input logic rst, input logic en);
      @(negedge clk);
      reset_n   = rst;
      habilitar = en;
      exp_q.push_back(model_out(mh, mv, en, 1280, 32, 192, 96, 480, 10, 2, 33));
      exp_s_q.push_back(model_out(sh, sv, en, 4, 1, 2, 1, 2, 1, 1, 1));
      #1;
      check("main", {6'b0, outcont, outcontv, hsync, vsync, video_on, fin_linea, fin_cuadro},
            exp_q.pop_front());
      check("small", {6'b0, s_outcont, s_outcontv, s_hsync, s_vsync, s_video_on, s_fin_linea,
                      s_fin_cuadro}, exp_s_q.pop_front());
`ifdef CONTADOR_CUADROS_EN
      check("main_cuadros", {24'b0, cuenta_cuadros}, {24'b0, mcnt});
      check("small_cuadros", {24'b0, s_cuenta_cuadros}, {24'b0, scnt});
`endif
      advance(mh, mv, mcnt, rst, en, 1600, 525);
      advance(sh, sv, scnt, rst, en, 8, 5);
   endtask

   initial begin
      reset_n   = 1'b0;
      habilitar = 1'b1;
      mh = 0; mv = 0; sh = 0; sv = 0; mcnt = 8'd0; scnt = 8'd0;

      // Reset held for five edges with enable high.
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_outcont",    {21'b0, outcont},     32'd0);
      check("rst_outcontv",   {22'b0, outcontv},    32'd0);
      check("rst_hsync",      {31'b0, hsync},       32'd1);
      check("rst_vsync",      {31'b0, vsync},       32'd1);
      check("rst_video_on",   {31'b0, video_on},    32'd1);
      check("rst_fin_linea",  {31'b0, fin_linea},   32'd0);
      check("rst_fin_cuadro", {31'b0, fin_cuadro},  32'd0);

      // Line sweep up to the last tick of the first line.
      for (int i = 0; i < 1599; i++) step(1'b1, 1'b1);
      @(posedge clk);
      #1;
      check("sweep_at_1599",  {21'b0, outcont},   32'd1599);
      check("sweep_fin_linea", {31'b0, fin_linea}, 32'd1);
      step(1'b1, 1'b1);
      @(posedge clk);
      #1;
      check("sweep_wrap_h", {21'b0, outcont},  32'd0);
      check("sweep_wrap_v", {22'b0, outcontv}, 32'd1);

      // Run to the end of line 1, then freeze for ten cycles and resume.
      for (int i = 0; i < 2000 && mh != 1599; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
      @(posedge clk);
      #1;
      check("hold_outcont",   {21'b0, outcont},   32'd1599);
      check("hold_outcontv",  {22'b0, outcontv},  32'd1);
      check("hold_fin_linea", {31'b0, fin_linea}, 32'd0);
      step(1'b1, 1'b1);
      @(posedge clk);
      #1;
      check("resume_wrap_h", {21'b0, outcont},  32'd0);
      check("resume_wrap_v", {22'b0, outcontv}, 32'd2);

      // Reset for one edge in the middle of a line.
      for (int i = 0; i < 2000 && mh != 700; i++) step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      @(posedge clk);
      #1;
      check("midrst_outcont",  {21'b0, outcont},  32'd0);
      check("midrst_outcontv", {22'b0, outcontv}, 32'd0);
      check("midrst_hsync",    {31'b0, hsync},    32'd1);
      check("midrst_vsync",    {31'b0, vsync},    32'd1);

      // Long run: the reduced instance passes 256+ frames, with occasional enable gaps.
      for (int i = 0; i < 11000; i++) begin
         step(1'b1, (i % 97) != 50);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
